soc_io_bridge: RTL

//  Memory-mapped I/O bridge between the MIPS core data port and data memory. Decodes an I/O

---
 rtl/soc_io_pkg.sv | 39 +++
 rtl/soc_io_bridge_rx_fifo.sv | 64 ++++++
 rtl/soc_io_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/soc_io_pkg.sv
// Purpose: shared register map, CTRL bit positions, store-strobe encodings and the
// STATUS word layout for the I/O bridge and its receive FIFOs.
package soc_io_pkg;

  // Register offsets within a channel window (dataadr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // CTRL write bit indices
  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  // Core store strobe encodings
  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b11;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY  = 16;
  localparam int unsigned ST_FULL   = 17;
  localparam int unsigned ST_OVF    = 18;
  localparam int unsigned ST_IRQ_EN = 19;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned REG_W  = 32;

  // STATUS register payload, LSB first: count, empty, full, overflow, irq_en
  typedef struct packed {
    logic [11:0] rsvd;
    logic        irq_en;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } status_t;

endpackage

// File: rtl/soc_io_bridge_rx_fifo.sv
// Purpose: byte-wide receive FIFO with push/pop/flush; flush beats push and pop.
// Ports: clk, reset (async active-low), push, pop, flush, din[7:0];
//        head_c (byte at head), count_c (0..DEPTH), empty_c, full_c, accept_c (push taken).
module rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               head_c,
  output logic [$clog2(DEPTH):0]   count_c,
  output logic                     empty_c,
  output logic                     full_c,
  output logic                     accept_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        pop_ok;

  // Status, accept decision and next pointers/storage
  always_comb begin
    count_c  = wr_ptr_q - rd_ptr_q;
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (count_c == (AW+1)'(DEPTH));
    head_c   = mem_q[rd_ptr_q[AW-1:0]];
    pop_ok   = pop & ~empty_c & ~flush;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    accept_c = push & ~flush & (~full_c | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (accept_c) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/soc_io_bridge.sv
// Purpose: memory-mapped I/O bridge between the core data port and data memory.
// Accesses to the I/O page hit NCH receive channels (DATA/STATUS/CTRL); all others pass
// through to memory. Keeps per-channel overflow/irq_en, a registered irq and rx_check.
// Ports: clk, reset (async active-low); core side dataadr, writedata, memwrite, memread,
//        readdata; memory side mem_memwrite, mem_readdata; rx_valid/rx_data per channel;
//        irq and rx_check (registered).
module soc_io_bridge
  import soc_io_pkg::*;
#(
  parameter int unsigned   N       = 64,
  parameter int unsigned   NCH     = 4,
  parameter int unsigned   DEPTH   = 16,
  parameter logic [N-9:0]  IO_PAGE = 'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         dataadr,
  input  logic [N-1:0]         writedata,
  input  logic [1:0]           memwrite,
  input  logic                 memread,
  output logic [N-1:0]         readdata,
  output logic [1:0]           mem_memwrite,
  input  logic [N-1:0]         mem_readdata,
  input  logic [NCH-1:0]       rx_valid,
  input  logic [BYTE_W*NCH-1:0] rx_data,
  output logic                 irq,
  output logic [31:0]          rx_check
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             hit;
  logic [3:0]       ch;
  logic [1:0]       rsel;
  logic [NCH-1:0]   sel, pop, ctrl_wr, flush, clr_ovf;
  logic [NCH-1:0]   empty_c, full_c, accept_c;
  logic [7:0]       head_c  [NCH];
  logic [CW-1:0]    count_c [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d, irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [31:0]      rx_check_q, rx_check_d;
  logic [REG_W-1:0] io_rd;
  status_t          st;
  logic             unused_bits;

  assign unused_bits = ^{writedata[N-1:3], dataadr[1:0]};

  // Address decode into per-channel strobes
  always_comb begin
    hit  = (dataadr[N-1:8] == IO_PAGE);
    ch   = dataadr[7:4];
    rsel = dataadr[3:2];
    for (int c = 0; c < int'(NCH); c++) begin
      sel[c]     = hit && (ch == 4'(c));
      pop[c]     = sel[c] && (rsel == REG_DATA) && memread;
      ctrl_wr[c] = sel[c] && (rsel == REG_CTRL) && (memwrite != MW_NONE);
      flush[c]   = ctrl_wr[c] & writedata[CTRL_FLUSH];
      clr_ovf[c] = ctrl_wr[c] & writedata[CTRL_CLR_OVF];
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
    rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (rx_valid[g]),
      .pop      (pop[g]),
      .flush    (flush[g]),
      .din      (rx_data[BYTE_W*g +: BYTE_W]),
      .head_c   (head_c[g]),
      .count_c  (count_c[g]),
      .empty_c  (empty_c[g]),
      .full_c   (full_c[g]),
      .accept_c (accept_c[g])
    );
  end

  // Next state for overflow, irq_en, irq and the accepted-byte counter
  always_comb begin
    ovf_d      = ovf_q;
    irq_en_d   = irq_en_q;
    rx_check_d = rx_check_q;
    for (int c = 0; c < int'(NCH); c++) begin
      if (clr_ovf[c]) ovf_d[c] = 1'b0;
      // A new drop outranks a clear in the same cycle; flushed bytes never count as drops
      if (rx_valid[c] && !accept_c[c] && !flush[c]) ovf_d[c] = 1'b1;
      if (ctrl_wr[c]) irq_en_d[c] = writedata[CTRL_IRQ_EN];
      rx_check_d = rx_check_d + 32'(accept_c[c]);
    end
    irq_d = |(irq_en_q & ~empty_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q      <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rx_check_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rx_check_q <= rx_check_d;
    end
  end

  // Register read mux and memory pass-through
  always_comb begin
    io_rd = '0;
    st    = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (sel[c]) begin
        case (rsel)
          REG_DATA:   if (!empty_c[c]) io_rd = REG_W'({1'b1, head_c[c]});
          REG_STATUS: begin
            st.count    = 16'(count_c[c]);
            st.empty    = empty_c[c];
            st.full     = full_c[c];
            st.overflow = ovf_q[c];
            st.irq_en   = irq_en_q[c];
            io_rd       = st;
          end
          REG_CTRL:   io_rd = REG_W'({irq_en_q[c], 2'b00});
          default:    io_rd = '0;
        endcase
      end
    end
    readdata     = hit ? N'(io_rd) : mem_readdata;
    mem_memwrite = hit ? MW_NONE : memwrite;
  end

  assign irq      = irq_q;
  assign rx_check = rx_check_q;

endmodule
